obstacle_frame_bank: RTL and testbench
======================================

Name: obstacle_frame_bank

Overview:
- Parametrised, double-buffered successor to the on-screen obstacle collector.
- Captures one frame's streamed environment polygons into a back bank and culls each polygon by bounding box against a camera window latched at frame start.
- Presents a stable front bank to the render stage; the back bank is promoted only on an explicit swap strobe, so geometry never changes mid-scan.

Parameters:
- WORLD_BITS, 32, signed coordinate width.
- MAX_OBSTACLES, 4, front/back bank polygon slots.
- MAX_VERTICES, 8, vertex slots per polygon.
- VIEW_WIDTH, 1280, camera window width in world units.
- VIEW_HEIGHT, 720, camera window height in world units.
- CULL_MARGIN, 0, extra world units added to each window side.

Ports:
- clk_in  in  1  system clock (pixel clock domain)
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  frame-capture start pulse (new_frame)
- camera_x_in, camera_y_in  in  WORLD_BITS  signed camera centre; sampled on accepted start_in
- valid_in  in  1  vertex beat valid
- x_in, y_in  in  WORLD_BITS  signed vertex coordinates
- last_in  in  1  qualifies valid_in: last vertex of the current polygon
- color_in  in  4  polygon colour; sampled with the last_in beat
- done_in  in  1  environment stream finished
- swap_in  in  1  promote-back-bank strobe (vertical blank)
- obstacle_xs_out, obstacle_ys_out  out  [MAX_OBSTACLES][MAX_VERTICES] x WORLD_BITS  front-bank vertices
- obstacles_num_sides_out  out  [MAX_OBSTACLES] x clog2(MAX_VERTICES+1)  front-bank vertex counts
- colors_out  out  [MAX_OBSTACLES] x 4  front-bank colours
- num_obstacles_out  out  clog2(MAX_OBSTACLES+1)  front-bank polygon count
- overflow_out  out  1  front-bank frame dropped polygons for capacity
- busy_out  out  1  high in CAPTURE or PENDING
- done_out  out  1  one-cycle pulse, cycle after a swap

Behaviour:
- Reset: state IDLE; bank select 0; both bank counts 0; every output 0. Bank contents need not be cleared; outputs beyond num_obstacles_out / num_sides are don't-care.
- Window bounds: computed in WORLD_BITS+2 signed arithmetic from the camera values latched on start_in.
  - xlo = cx - VIEW_WIDTH/2 - CULL_MARGIN; xhi = cx + VIEW_WIDTH/2 + CULL_MARGIN.
  - ylo and yhi are computed the same way with VIEW_HEIGHT.
  - Comparisons are inclusive.
- IDLE:
  - start_in: latch camera, clear back count, vertex index and poly overflow flag, clear frame overflow, go to CAPTURE.
  - valid_in, done_in and swap_in are ignored.
- CAPTURE, per valid_in beat:
  - If vertex index < MAX_VERTICES, write (x,y) to back[slot][idx] and increment idx.
  - Otherwise set the poly-overflow flag.
  - Running min/max x and y: the first beat of a polygon initialises them; later beats update them.
  - On a last_in beat, commit in the following cycle if all of these hold: poly-overflow is clear, slot < MAX_OBSTACLES, and the bbox overlaps the window (maxx >= xlo, minx <= xhi, maxy >= ylo, miny <= yhi). Commit stores num_sides = idx and the colour, then increments the back count.
  - If not committed: discard the polygon. If the drop was due to slot or vertex capacity, set frame overflow; a culled polygon does not set it.
  - In all cases reset idx and the poly-overflow flag.
  - A first beat immediately after last_in is accepted with no bubble.
- CAPTURE, on done_in:
  - If valid_in is also high, that beat is processed first.
  - A pending commit completes before entering PENDING.
  - An unterminated partial polygon is discarded without setting overflow.
- CAPTURE, start_in: abort and restart the capture (re-latch camera, clear back bank). The front bank is untouched.
- PENDING:
  - swap_in: toggle bank select, which makes the back bank the front bank and latches frame overflow into overflow_out. Next cycle done_out=1; go to IDLE.
  - start_in (with or without swap_in): the pending frame is discarded and capture restarts; start has priority.
- swap_in outside PENDING: ignored, and the front bank holds. This includes swap_in coinciding with the done_in cycle.
- Outputs are combinational muxes of the front bank by bank select, so they change only on the swap edge.
- Latency: last_in beat to back count increment = 1 cycle; swap_in to outputs changing = 1 edge; done_out = 1 cycle after that edge.

Test Plan:
- Reset, then inspect outputs → num_obstacles_out=0, overflow_out=0, busy_out=0, done_out=0.
- Camera (640,360), margin 0. Stream square (100,100),(100,200),(200,200),(200,100), colour 4'hB, then done_in and swap_in → num_obstacles_out=1, num_sides[0]=4, colors[0]=4'hB, done_out pulses once.
- Same camera. Stream polygon with all x in 1300..1400, then an on-screen triangle → only the triangle is stored (count=1, sides=3), overflow_out=0. A polygon touching x=1280 exactly is kept.
- Stream 5 visible polygons with MAX_OBSTACLES=4 → count=4, overflow_out=1. Stream one 9-vertex polygon → dropped, overflow_out=1.
- Capture a 2-polygon frame and swap. Then start a new capture and stream 1 polygon; hold swap_in low → outputs still show 2 polygons until done_in and swap_in, then 1.
- start_in mid-capture, and start_in together with swap_in in PENDING → front bank unchanged, busy_out stays 1, new frame captured cleanly. rst_in mid-CAPTURE → all outputs 0 next cycle.

Source files
------------

// File: rtl/obstacle_frame_bank.sv
// Double-buffered obstacle polygon store: captures one frame of streamed polygons into a
// back bank with bounding-box culling, and promotes it to the front bank on a swap strobe.
module obstacle_frame_bank #(
  parameter int WORLD_BITS    = 32,
  parameter int MAX_OBSTACLES = 4,
  parameter int MAX_VERTICES  = 8,
  parameter int VIEW_WIDTH    = 1280,
  parameter int VIEW_HEIGHT   = 720,
  parameter int CULL_MARGIN   = 0
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start_in,
  input  logic signed [WORLD_BITS-1:0]          camera_x_in,
  input  logic signed [WORLD_BITS-1:0]          camera_y_in,
  input  logic                                  valid_in,
  input  logic signed [WORLD_BITS-1:0]          x_in,
  input  logic signed [WORLD_BITS-1:0]          y_in,
  input  logic                                  last_in,
  input  logic [3:0]                            color_in,
  input  logic                                  done_in,
  input  logic                                  swap_in,
  output logic signed [WORLD_BITS-1:0]          obstacle_xs_out [MAX_OBSTACLES][MAX_VERTICES],
  output logic signed [WORLD_BITS-1:0]          obstacle_ys_out [MAX_OBSTACLES][MAX_VERTICES],
  output logic [$clog2(MAX_VERTICES+1)-1:0]     obstacles_num_sides_out [MAX_OBSTACLES],
  output logic [3:0]                            colors_out [MAX_OBSTACLES],
  output logic [$clog2(MAX_OBSTACLES+1)-1:0]    num_obstacles_out,
  output logic                                  overflow_out,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic [1:0]                            state_out
);

  localparam int XW     = WORLD_BITS + 2;
  localparam int SIDE_W = $clog2(MAX_VERTICES + 1);
  localparam int CNT_W  = $clog2(MAX_OBSTACLES + 1);
  localparam int SLOT_W = (MAX_OBSTACLES > 1) ? $clog2(MAX_OBSTACLES) : 1;
  localparam int VIDX_W = (MAX_VERTICES > 1) ? $clog2(MAX_VERTICES) : 1;
  localparam logic [SIDE_W-1:0]   MAXV   = SIDE_W'(MAX_VERTICES);
  localparam logic [CNT_W-1:0]    MAXO   = CNT_W'(MAX_OBSTACLES);
  localparam logic signed [XW-1:0] HALF_W = XW'(VIEW_WIDTH / 2 + CULL_MARGIN);
  localparam logic signed [XW-1:0] HALF_H = XW'(VIEW_HEIGHT / 2 + CULL_MARGIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t state, state_nx;

  logic signed [WORLD_BITS-1:0] xs_q [2][MAX_OBSTACLES][MAX_VERTICES];
  logic signed [WORLD_BITS-1:0] ys_q [2][MAX_OBSTACLES][MAX_VERTICES];
  logic [SIDE_W-1:0]            sides_q [2][MAX_OBSTACLES];
  logic [3:0]                   colors_q [2][MAX_OBSTACLES];
  logic [CNT_W-1:0]             cnt_q [2];

  logic                         bank_sel, back_sel;
  logic signed [WORLD_BITS-1:0] cam_x, cam_y;
  logic [SIDE_W-1:0]            idx;
  logic                         poly_ovf, frame_ovf;
  logic signed [XW-1:0]         minx, maxx, miny, maxy;

  logic signed [XW-1:0] xe, ye, cxe, cye, xlo, xhi, ylo, yhi;
  logic signed [XW-1:0] nminx, nmaxx, nminy, nmaxy;
  logic [CNT_W-1:0]     back_cnt;
  logic [SLOT_W-1:0]    slot;
  logic [VIDX_W-1:0]    vidx;
  logic                 first, slot_ok, vert_ok, ovf_now, visible, commit, cap_fail, beat;

  assign back_sel = ~bank_sel;
  assign xe  = {{2{x_in[WORLD_BITS-1]}}, x_in};
  assign ye  = {{2{y_in[WORLD_BITS-1]}}, y_in};
  assign cxe = {{2{cam_x[WORLD_BITS-1]}}, cam_x};
  assign cye = {{2{cam_y[WORLD_BITS-1]}}, cam_y};
  assign xlo = cxe - HALF_W;
  assign xhi = cxe + HALF_W;
  assign ylo = cye - HALF_H;
  assign yhi = cye + HALF_H;

  // Running bbox including the current beat, so the last beat can decide the commit directly.
  assign first = (idx == '0);
  assign nminx = (first || xe < minx) ? xe : minx;
  assign nmaxx = (first || xe > maxx) ? xe : maxx;
  assign nminy = (first || ye < miny) ? ye : miny;
  assign nmaxy = (first || ye > maxy) ? ye : maxy;

  assign back_cnt = cnt_q[back_sel];
  assign slot     = back_cnt[SLOT_W-1:0];
  assign vidx     = idx[VIDX_W-1:0];
  assign slot_ok  = (back_cnt < MAXO);
  assign vert_ok  = (idx < MAXV);
  assign ovf_now  = poly_ovf | ~vert_ok;
  assign visible  = (nmaxx >= xlo) && (nminx <= xhi) && (nmaxy >= ylo) && (nminy <= yhi);
  assign commit   = ~ovf_now & slot_ok & visible;
  assign cap_fail = ovf_now | ~slot_ok;

  // valid_in beats are accepted unconditionally in CAPTURE: there is no backpressure, and a
  // start_in in the same cycle wins over the beat.
  assign beat = (state == CAPTURE) && valid_in && !start_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_in) state_nx = CAPTURE;
      CAPTURE: if (start_in) state_nx = CAPTURE;
               else if (done_in) state_nx = PENDING;
      PENDING: if (start_in) state_nx = CAPTURE;
               else if (swap_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (beat) begin
      if (vert_ok && slot_ok) begin
        xs_q[back_sel][slot][vidx] <= x_in;
        ys_q[back_sel][slot][vidx] <= y_in;
      end
      if (last_in && commit) begin
        sides_q[back_sel][slot]  <= idx + SIDE_W'(1);
        colors_q[back_sel][slot] <= color_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bank_sel     <= 1'b0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      cam_x        <= '0;
      cam_y        <= '0;
      idx          <= '0;
      poly_ovf     <= 1'b0;
      frame_ovf    <= 1'b0;
      minx         <= '0;
      maxx         <= '0;
      miny         <= '0;
      maxy         <= '0;
      overflow_out <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (start_in) begin
        cam_x           <= camera_x_in;
        cam_y           <= camera_y_in;
        cnt_q[back_sel] <= '0;
        idx             <= '0;
        poly_ovf        <= 1'b0;
        frame_ovf       <= 1'b0;
      end else if (beat) begin
        minx <= nminx;
        maxx <= nmaxx;
        miny <= nminy;
        maxy <= nmaxy;
        if (vert_ok) idx <= idx + SIDE_W'(1);
        else         poly_ovf <= 1'b1;
        if (last_in) begin
          if (commit)        cnt_q[back_sel] <= back_cnt + CNT_W'(1);
          else if (cap_fail) frame_ovf <= 1'b1;
          idx      <= '0;
          poly_ovf <= 1'b0;
        end
      end else if (state == PENDING && swap_in) begin
        bank_sel     <= ~bank_sel;
        overflow_out <= frame_ovf;
        done_out     <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_OBSTACLES; i++) begin
      for (int j = 0; j < MAX_VERTICES; j++) begin
        obstacle_xs_out[i][j] = xs_q[bank_sel][i][j];
        obstacle_ys_out[i][j] = ys_q[bank_sel][i][j];
      end
      obstacles_num_sides_out[i] = sides_q[bank_sel][i];
      colors_out[i]              = colors_q[bank_sel][i];
    end
  end

  assign num_obstacles_out = cnt_q[bank_sel];
  assign busy_out          = (state != IDLE);
  assign state_out         = state;

endmodule

// File: tb/tb_obstacle_frame_bank.sv
// Bench for obstacle_frame_bank: directed scenarios plus randomized frames checked against a
// list-based model of cull/capacity rules.
module tb_obstacle_frame_bank;

  localparam int W      = 32;
  localparam int MAXO   = 4;
  localparam int MAXV   = 8;
  localparam int VIEW_W = 1280;
  localparam int VIEW_H = 720;
  localparam int MARGIN = 0;

  logic clk = 1'b0;
  logic rst_in = 1'b0, start_in = 1'b0, valid_in = 1'b0, last_in = 1'b0;
  logic done_in = 1'b0, swap_in = 1'b0;
  logic signed [W-1:0] camera_x_in = '0, camera_y_in = '0, x_in = '0, y_in = '0;
  logic [3:0] color_in = '0;
  logic signed [W-1:0] obs_xs [MAXO][MAXV];
  logic signed [W-1:0] obs_ys [MAXO][MAXV];
  logic [3:0] num_sides [MAXO];
  logic [3:0] colors [MAXO];
  logic [2:0] num_obstacles_out;
  logic overflow_out, busy_out, done_out;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the frame being streamed, flattened: vertex lists plus per-polygon length/colour.
  int f_x[$], f_y[$], f_len[$];
  logic [3:0] f_col[$];
  int m_cx, m_cy;
  logic [W-1:0] exp_q[$];
  int pv_x[16], pv_y[16];
  int plen;

  obstacle_frame_bank dut (
    .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
    .camera_x_in(camera_x_in), .camera_y_in(camera_y_in),
    .valid_in(valid_in), .x_in(x_in), .y_in(y_in), .last_in(last_in),
    .color_in(color_in), .done_in(done_in), .swap_in(swap_in),
    .obstacle_xs_out(obs_xs), .obstacle_ys_out(obs_ys),
    .obstacles_num_sides_out(num_sides), .colors_out(colors),
    .num_obstacles_out(num_obstacles_out), .overflow_out(overflow_out),
    .busy_out(busy_out), .done_out(done_out), .state_out(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic start_frame(input int cx, input int cy);
    start_in = 1'b1;
    camera_x_in = cx;
    camera_y_in = cy;
    tick();
    start_in = 1'b0;
    m_cx = cx;
    m_cy = cy;
    f_x.delete(); f_y.delete(); f_len.delete(); f_col.delete();
  endtask

  task automatic drive_beat(input int x, input int y, input bit last, input logic [3:0] col,
                            input bit done);
    valid_in = 1'b1; x_in = x; y_in = y; last_in = last; color_in = col; done_in = done;
    tick();
    valid_in = 1'b0; last_in = 1'b0; done_in = 1'b0;
  endtask

  task automatic send_poly(input logic [3:0] col, input bit with_done);
    for (int i = 0; i < plen; i++)
      drive_beat(pv_x[i], pv_y[i], i == plen - 1, col, with_done && (i == plen - 1));
    f_len.push_back(plen);
    f_col.push_back(col);
    for (int i = 0; i < plen; i++) begin
      f_x.push_back(pv_x[i]);
      f_y.push_back(pv_y[i]);
    end
  endtask

  task automatic drive_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic drive_swap();
    swap_in = 1'b1;
    tick();
    swap_in = 1'b0;
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
    plen = 3;
    pv_x[0] = x0; pv_y[0] = y0; pv_x[1] = x1; pv_y[1] = y1; pv_x[2] = x2; pv_y[2] = y2;
  endtask

  task automatic set_rect(input int xa, input int ya, input int xb, input int yb);
    plen = 4;
    pv_x[0] = xa; pv_y[0] = ya; pv_x[1] = xa; pv_y[1] = yb;
    pv_x[2] = xb; pv_y[2] = yb; pv_x[3] = xb; pv_y[3] = ya;
  endtask

  // ---------------- scoreboard model ----------------
  // Pushes the expected front bank after a swap: count, overflow, then per kept polygon
  // sides, colour and its vertices as x,y pairs.
  task automatic model_frame();
    longint xlo, xhi, ylo, yhi, mnx, mxx, mny, mxy;
    int kept_base[$];
    int kept_poly[$];
    bit ovf;
    int base;
    xlo = longint'(m_cx) - VIEW_W / 2 - MARGIN;
    xhi = longint'(m_cx) + VIEW_W / 2 + MARGIN;
    ylo = longint'(m_cy) - VIEW_H / 2 - MARGIN;
    yhi = longint'(m_cy) + VIEW_H / 2 + MARGIN;
    ovf = 1'b0;
    base = 0;
    exp_q.delete();
    for (int p = 0; p < f_len.size(); p++) begin
      bit vis, cap_fail;
      mnx = f_x[base]; mxx = f_x[base]; mny = f_y[base]; mxy = f_y[base];
      for (int k = base; k < base + f_len[p]; k++) begin
        if (f_x[k] < mnx) mnx = f_x[k];
        if (f_x[k] > mxx) mxx = f_x[k];
        if (f_y[k] < mny) mny = f_y[k];
        if (f_y[k] > mxy) mxy = f_y[k];
      end
      vis = (mxx >= xlo) && (mnx <= xhi) && (mxy >= ylo) && (mny <= yhi);
      cap_fail = (f_len[p] > MAXV) || (kept_poly.size() >= MAXO);
      if (!cap_fail && vis) begin
        kept_base.push_back(base);
        kept_poly.push_back(p);
      end else if (cap_fail) begin
        ovf = 1'b1;
      end
      base += f_len[p];
    end
    exp_q.push_back(W'(kept_poly.size()));
    exp_q.push_back(W'(ovf));
    for (int i = 0; i < kept_poly.size(); i++) begin
      exp_q.push_back(W'(f_len[kept_poly[i]]));
      exp_q.push_back(W'(f_col[kept_poly[i]]));
      for (int k = 0; k < f_len[kept_poly[i]]; k++) begin
        exp_q.push_back(W'(f_x[kept_base[i] + k]));
        exp_q.push_back(W'(f_y[kept_base[i] + k]));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (num_obstacles_out !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", num_obstacles_out); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_out); end
    n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_out); end
  endtask

  task automatic test_square();
    start_frame(640, 360);
    set_rect(100, 100, 200, 200);
    send_poly(4'hB, 1'b0);
    drive_done();
    n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL square_busy_pending got %b want 1", busy_out); end
    n_cmp++; if (num_obstacles_out !== 3'd0) begin n_err++; $display("FAIL square_front_held got %0d want 0", num_obstacles_out); end
    drive_swap();
    n_cmp++; if (done_out !== 1'b1) begin n_err++; $display("FAIL square_done_pulse got %b want 1", done_out); end
    n_cmp++; if (num_obstacles_out !== 3'd1) begin n_err++; $display("FAIL square_count got %0d want 1", num_obstacles_out); end
    n_cmp++; if (num_sides[0] !== 4'd4) begin n_err++; $display("FAIL square_sides got %0d want 4", num_sides[0]); end
    n_cmp++; if (colors[0] !== 4'hB) begin n_err++; $display("FAIL square_color got %h want b", colors[0]); end
    n_cmp++; if (obs_xs[0][2] !== 200 || obs_ys[0][1] !== 200) begin n_err++; $display("FAIL square_vertex got (%0d,%0d) want (200,200)", obs_xs[0][2], obs_ys[0][1]); end
    tick();
    n_cmp++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL square_done_clear got done=%b busy=%b want 0 0", done_out, busy_out); end
  endtask

  task automatic test_cull();
    start_frame(640, 360);
    set_rect(1300, 100, 1400, 200);
    send_poly(4'h1, 1'b0);
    set_tri(10, 10, 50, 10, 30, 50);
    send_poly(4'h3, 1'b0);
    set_tri(1280, 300, 1500, 300, 1500, 400);
    send_poly(4'h5, 1'b1);
    drive_swap();
    n_cmp++; if (num_obstacles_out !== 3'd2) begin n_err++; $display("FAIL cull_count got %0d want 2", num_obstacles_out); end
    n_cmp++; if (num_sides[0] !== 4'd3 || colors[0] !== 4'h3) begin n_err++; $display("FAIL cull_tri got sides=%0d col=%h want 3 3", num_sides[0], colors[0]); end
    n_cmp++; if (colors[1] !== 4'h5 || obs_xs[1][0] !== 1280) begin n_err++; $display("FAIL cull_edge got col=%h x=%0d want 5 1280", colors[1], obs_xs[1][0]); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL cull_overflow got %b want 0", overflow_out); end
  endtask

  task automatic test_capacity();
    start_frame(640, 360);
    for (int p = 0; p < 5; p++) begin
      set_tri(10 + p, 10, 50, 10, 30, 50);
      send_poly(4'(p + 1), 1'b0);
    end
    drive_done();
    drive_swap();
    n_cmp++; if (num_obstacles_out !== 3'd4) begin n_err++; $display("FAIL cap_slots_count got %0d want 4", num_obstacles_out); end
    n_cmp++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL cap_slots_overflow got %b want 1", overflow_out); end
    n_cmp++; if (colors[3] !== 4'h4) begin n_err++; $display("FAIL cap_slots_last got %h want 4", colors[3]); end
    start_frame(640, 360);
    plen = 9;
    for (int i = 0; i < 9; i++) begin pv_x[i] = 100 + 10 * i; pv_y[i] = 100 + i; end
    send_poly(4'hE, 1'b0);
    plen = 8;
    for (int i = 0; i < 8; i++) begin pv_x[i] = 300 + 5 * i; pv_y[i] = 400 - i; end
    send_poly(4'hD, 1'b0);
    drive_done();
    drive_swap();
    n_cmp++; if (num_obstacles_out !== 3'd1) begin n_err++; $display("FAIL cap_verts_count got %0d want 1", num_obstacles_out); end
    n_cmp++; if (num_sides[0] !== 4'd8 || colors[0] !== 4'hD) begin n_err++; $display("FAIL cap_verts_kept got sides=%0d col=%h want 8 d", num_sides[0], colors[0]); end
    n_cmp++; if (obs_xs[0][7] !== 335 || obs_ys[0][7] !== 393) begin n_err++; $display("FAIL cap_verts_last got (%0d,%0d) want (335,393)", obs_xs[0][7], obs_ys[0][7]); end
    n_cmp++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL cap_verts_overflow got %b want 1", overflow_out); end
  endtask

  task automatic test_reset_mid();
    start_frame(640, 360);
    drive_beat(10, 10, 1'b0, 4'h2, 1'b0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    n_cmp++; if (num_obstacles_out !== 3'd0 || overflow_out !== 1'b0) begin n_err++; $display("FAIL rstmid_front got cnt=%0d ovf=%b want 0 0", num_obstacles_out, overflow_out); end
    n_cmp++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin n_err++; $display("FAIL rstmid_status got busy=%b done=%b want 0 0", busy_out, done_out); end
  endtask

  task automatic test_back_to_back();
    start_frame(640, 360);
    set_rect(10, 10, 20, 20);
    send_poly(4'h1, 1'b0);
    set_rect(30, 30, 40, 40);
    send_poly(4'h2, 1'b1);
    drive_swap();
    tick();
    start_frame(640, 360);
    set_tri(5, 5, 60, 5, 30, 60);
    send_poly(4'h9, 1'b0);
    tick(); tick(); tick();
    n_cmp++; if (num_obstacles_out !== 3'd2 || colors[0] !== 4'h1) begin n_err++; $display("FAIL b2b_hold got cnt=%0d col=%h want 2 1", num_obstacles_out, colors[0]); end
    drive_swap();
    n_cmp++; if (num_obstacles_out !== 3'd2 || done_out !== 1'b0) begin n_err++; $display("FAIL b2b_swap_in_capture got cnt=%0d done=%b want 2 0", num_obstacles_out, done_out); end
    done_in = 1'b1; swap_in = 1'b1;
    tick();
    done_in = 1'b0; swap_in = 1'b0;
    n_cmp++; if (num_obstacles_out !== 3'd2 || busy_out !== 1'b1) begin n_err++; $display("FAIL b2b_swap_with_done got cnt=%0d busy=%b want 2 1", num_obstacles_out, busy_out); end
    drive_swap();
    n_cmp++; if (num_obstacles_out !== 3'd1 || num_sides[0] !== 4'd3 || colors[0] !== 4'h9) begin n_err++; $display("FAIL b2b_new_front got cnt=%0d sides=%0d col=%h want 1 3 9", num_obstacles_out, num_sides[0], colors[0]); end
    tick();
  endtask

  task automatic test_restart();
    start_frame(640, 360);
    set_rect(10, 10, 20, 20);
    send_poly(4'h4, 1'b0);
    set_rect(30, 30, 40, 40);
    send_poly(4'h5, 1'b0);
    drive_beat(70, 70, 1'b0, 4'h6, 1'b0);
    start_frame(640, 360);
    n_cmp++; if (busy_out !== 1'b1 || num_obstacles_out !== 3'd1) begin n_err++; $display("FAIL restart_mid got busy=%b cnt=%0d want 1 1", busy_out, num_obstacles_out); end
    set_rect(50, 50, 60, 60);
    send_poly(4'h7, 1'b1);
    start_in = 1'b1; swap_in = 1'b1;
    tick();
    start_in = 1'b0; swap_in = 1'b0;
    n_cmp++; if (busy_out !== 1'b1 || done_out !== 1'b0) begin n_err++; $display("FAIL restart_pending got busy=%b done=%b want 1 0", busy_out, done_out); end
    n_cmp++; if (num_obstacles_out !== 3'd1 || colors[0] !== 4'h9) begin n_err++; $display("FAIL restart_front got cnt=%0d col=%h want 1 9", num_obstacles_out, colors[0]); end
    for (int p = 0; p < 3; p++) begin
      set_tri(100 + p, 100, 150, 100, 120, 150);
      send_poly(4'(p + 10), 1'b0);
    end
    drive_done();
    drive_swap();
    n_cmp++; if (num_obstacles_out !== 3'd3 || colors[0] !== 4'hA || overflow_out !== 1'b0) begin n_err++; $display("FAIL restart_new got cnt=%0d col=%h ovf=%b want 3 a 0", num_obstacles_out, colors[0], overflow_out); end
    tick();
  endtask

  task automatic test_random();
    for (int f = 0; f < 14; f++) begin
      int np, partial;
      bit done_sent;
      logic [W-1:0] e;
      int cnt;
      start_frame(int'($urandom_range(0, 200000)) - 100000, int'($urandom_range(0, 200000)) - 100000);
      np = $urandom_range(0, 6);
      partial = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      done_sent = 1'b0;
      for (int p = 0; p < np; p++) begin
        int bx, by;
        bit wd;
        plen = $urandom_range(1, 10);
        if ($urandom_range(0, 3) == 0) begin
          bx = m_cx + 700 + int'($urandom_range(0, 400));
          by = m_cy - 100;
        end else begin
          bx = m_cx + int'($urandom_range(0, 1400)) - 800;
          by = m_cy + int'($urandom_range(0, 900)) - 500;
        end
        for (int i = 0; i < plen; i++) begin
          pv_x[i] = bx + int'($urandom_range(0, 200));
          pv_y[i] = by + int'($urandom_range(0, 200));
        end
        wd = (p == np - 1) && (partial == 0) && ($urandom_range(0, 1) == 1);
        send_poly(4'($urandom_range(0, 15)), wd);
        done_sent = done_sent | wd;
        if ($urandom_range(0, 3) == 0) tick();
      end
      for (int i = 0; i < partial; i++) drive_beat(m_cx, m_cy, 1'b0, 4'h0, 1'b0);
      if (!done_sent) drive_done();
      model_frame();
      drive_swap();
      n_cmp++; if (done_out !== 1'b1) begin n_err++; $display("FAIL rand%0d_done got %b want 1", f, done_out); end
      e = exp_q.pop_front();
      cnt = int'(e);
      n_cmp++; if (W'(num_obstacles_out) !== e) begin n_err++; $display("FAIL rand%0d_count got %0d want %0d", f, num_obstacles_out, e); end
      e = exp_q.pop_front();
      n_cmp++; if (W'(overflow_out) !== e) begin n_err++; $display("FAIL rand%0d_overflow got %b want %0d", f, overflow_out, e); end
      for (int i = 0; i < cnt && i < MAXO; i++) begin
        int ns;
        e = exp_q.pop_front();
        ns = int'(e);
        n_cmp++; if (W'(num_sides[i]) !== e) begin n_err++; $display("FAIL rand%0d_sides[%0d] got %0d want %0d", f, i, num_sides[i], e); end
        e = exp_q.pop_front();
        n_cmp++; if (W'(colors[i]) !== e) begin n_err++; $display("FAIL rand%0d_color[%0d] got %h want %h", f, i, colors[i], e); end
        for (int k = 0; k < ns && k < MAXV; k++) begin
          e = exp_q.pop_front();
          n_cmp++; if (obs_xs[i][k] !== e) begin n_err++; $display("FAIL rand%0d_x[%0d][%0d] got %0d want %0d", f, i, k, obs_xs[i][k], $signed(e)); end
          e = exp_q.pop_front();
          n_cmp++; if (obs_ys[i][k] !== e) begin n_err++; $display("FAIL rand%0d_y[%0d][%0d] got %0d want %0d", f, i, k, obs_ys[i][k], $signed(e)); end
        end
      end
      tick();
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_square();
    test_cull();
    test_capacity();
    test_reset_mid();
    test_back_to_back();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
